key_demux: RTL and testbench

Distributes a single incoming key/command byte stream (one strobe per byte) to two per-player queues, each drained by that player's game logic through a valid/ready handshake. In single-player mode every byte is broadcast to both queues. In two-player mode each byte is steered to exactly one queue by code range. It sits between the shared input decoder and the two player controllers. It is the receive-side counterpart of the select logic that drives player outputs from either a shared source or per-player sources.

---
 rtl/drag_racing_pkg.sv | 13 +
 rtl/key_demux_byte_fifo.sv | 75 +++++++
 rtl/key_demux.sv | 122 ++++++++++++
 tb/tb_key_demux.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/drag_racing_pkg.sv
// Shared definitions for the drag-racing input path: byte width,
// player index constants and the key/command byte type.
package drag_racing_pkg;

    localparam int BYTE_W = 8;

    // Player indices used to address per-player signal vectors.
    localparam int P1 = 0;
    localparam int P2 = 1;

    typedef logic [BYTE_W-1:0] key_code_t;

endpackage : drag_racing_pkg

// File: rtl/key_demux_byte_fifo.sv
// Circular byte queue with registered storage, write/read pointers and an
// occupancy count. A push into a full queue is accepted only when a pop
// happens in the same cycle; a pop on an empty queue is ignored.
module byte_fifo
    import drag_racing_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  key_code_t              wr_data,
    input  logic                   rd_en,
    output key_code_t              rd_data,
    output logic                   empty,
    output logic                   full,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    key_code_t      mem_q [DEPTH];
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [AW:0]    count_q, count_d;
    logic           do_rd;
    logic           do_wr;

    assign empty   = (count_q == '0);
    assign full    = (count_q == FULL_CNT);
    assign count   = count_q;
    assign rd_data = mem_q[rd_ptr_q];

    assign do_rd = rd_en & ~empty;
    assign do_wr = wr_en & (~full | do_rd);

    // Next pointer and occupancy values; pointers wrap naturally at DEPTH.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_wr) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_rd) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({do_wr, do_rd})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Pointer/count registers; storage is cleared so the head reads 0 after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (do_wr) begin
                mem_q[wr_ptr_q] <= wr_data;
            end
        end
    end

endmodule : byte_fifo

// File: rtl/key_demux.sv
// Steers one key/command byte stream into two per-player queues.
// Broadcast mode pushes atomically into both queues; two-player mode picks
// one queue by comparing the code with SPLIT. Dropped bytes raise a sticky
// per-player overflow flag.
//
// Handshake: pX_valid means the queue holds a byte at pX_data; the byte is
// consumed on a rising edge where pX_valid and pX_ready are both high.
// pX_data stays stable while pX_valid is high and pX_ready is low. The input
// side has no backpressure: a strobe either lands or is dropped.
module key_demux
    import drag_racing_pkg::*;
#(
    parameter int        DEPTH = 4,
    parameter key_code_t SPLIT = 8'h80
) (
    input  logic      clk,
    input  logic      rst,
    input  key_code_t in_data,
    input  logic      in_valid,
    input  logic      two_player,
    output key_code_t p1_data,
    output key_code_t p2_data,
    output logic      p1_valid,
    output logic      p2_valid,
    input  logic      p1_ready,
    input  logic      p2_ready,
    output logic      p1_ovf,
    output logic      p2_ovf,
    input  logic      clr_ovf
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [1:0]    empty;
    logic [1:0]    full;
    logic [1:0]    pop;
    logic [1:0]    space;
    logic [1:0]    push;
    logic [1:0]    drop;
    logic [1:0]    ovf_q, ovf_d;
    logic          to_p2;
    logic [CW-1:0] p1_count;
    logic [CW-1:0] p2_count;
    logic          unused_counts;

    assign p1_valid = ~empty[P1];
    assign p2_valid = ~empty[P2];

    assign pop[P1] = p1_valid & p1_ready;
    assign pop[P2] = p2_valid & p2_ready;

    // A full queue can still take a byte when its head leaves in the same cycle.
    assign space = ~full | pop;

    assign to_p2 = (in_data >= SPLIT);

    // Occupancy is available for debug probes but routing only needs full/empty.
    assign unused_counts = ^{p1_count, p2_count};

    // Routing: steer by code range, or broadcast only when both queues can take it.
    always_comb begin
        push = 2'b00;
        drop = 2'b00;
        if (in_valid) begin
            if (two_player) begin
                if (to_p2) begin
                    push[P2] = space[P2];
                    drop[P2] = ~space[P2];
                end else begin
                    push[P1] = space[P1];
                    drop[P1] = ~space[P1];
                end
            end else if (&space) begin
                push = 2'b11;
            end else begin
                drop = ~space;
            end
        end
    end

    // Sticky overflow: a drop in the same cycle as clr_ovf keeps the flag set.
    always_comb begin
        ovf_d = drop | (ovf_q & ~{2{clr_ovf}});
    end

    // Overflow flag register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 2'b00;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign p1_ovf = ovf_q[P1];
    assign p2_ovf = ovf_q[P2];

    byte_fifo #(.DEPTH(DEPTH)) u_p1_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (push[P1]),
        .wr_data (in_data),
        .rd_en   (pop[P1]),
        .rd_data (p1_data),
        .empty   (empty[P1]),
        .full    (full[P1]),
        .count   (p1_count)
    );

    byte_fifo #(.DEPTH(DEPTH)) u_p2_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (push[P2]),
        .wr_data (in_data),
        .rd_en   (pop[P2]),
        .rd_data (p2_data),
        .empty   (empty[P2]),
        .full    (full[P2]),
        .count   (p2_count)
    );

endmodule : key_demux

// File: tb/tb_key_demux.sv
// Directed bench for key_demux: a queue-based reference model of the two
// player queues and overflow flags, checked on every falling edge, plus
// literal expectations at the interesting points of each scenario.
module tb_key_demux;

    localparam int DEPTH = 4;

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] in_data;
    logic       in_valid;
    logic       two_player;
    logic [7:0] p1_data, p2_data;
    logic       p1_valid, p2_valid;
    logic       p1_ready, p2_ready;
    logic       p1_ovf, p2_ovf;
    logic       clr_ovf;

    always #5 clk = ~clk;

    key_demux #(.DEPTH(DEPTH), .SPLIT(8'h80)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .two_player (two_player),
        .p1_data    (p1_data),
        .p2_data    (p2_data),
        .p1_valid   (p1_valid),
        .p2_valid   (p2_valid),
        .p1_ready   (p1_ready),
        .p2_ready   (p2_ready),
        .p1_ovf     (p1_ovf),
        .p2_ovf     (p2_ovf),
        .clr_ovf    (clr_ovf)
    );

    // ---------------- scoreboard ----------------
    int total = 0;
    int bad   = 0;

    logic [7:0] exp_q1[$];
    logic [7:0] exp_q2[$];
    logic       exp_ovf1;
    logic       exp_ovf2;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: each queue is a plain FIFO of at most DEPTH bytes.
    always @(posedge clk or posedge rst) begin : model
        bit pop1, pop2, room1, room2;
        if (rst) begin
            exp_q1.delete();
            exp_q2.delete();
            exp_ovf1 = 1'b0;
            exp_ovf2 = 1'b0;
        end else begin
            pop1  = p1_ready && (exp_q1.size() > 0);
            pop2  = p2_ready && (exp_q2.size() > 0);
            room1 = (exp_q1.size() < DEPTH) || pop1;
            room2 = (exp_q2.size() < DEPTH) || pop2;
            if (pop1) void'(exp_q1.pop_front());
            if (pop2) void'(exp_q2.pop_front());
            if (clr_ovf) begin
                exp_ovf1 = 1'b0;
                exp_ovf2 = 1'b0;
            end
            if (in_valid) begin
                if (two_player) begin
                    if (in_data < 8'h80) begin
                        if (room1) exp_q1.push_back(in_data);
                        else       exp_ovf1 = 1'b1;
                    end else begin
                        if (room2) exp_q2.push_back(in_data);
                        else       exp_ovf2 = 1'b1;
                    end
                end else if (room1 && room2) begin
                    exp_q1.push_back(in_data);
                    exp_q2.push_back(in_data);
                end else begin
                    if (!room1) exp_ovf1 = 1'b1;
                    if (!room2) exp_ovf2 = 1'b1;
                end
            end
        end
    end

    // Compare process: outputs are settled mid-cycle.
    always @(negedge clk) begin
        check("p1_valid", {7'd0, p1_valid}, {7'd0, exp_q1.size() > 0});
        check("p2_valid", {7'd0, p2_valid}, {7'd0, exp_q2.size() > 0});
        check("p1_ovf",   {7'd0, p1_ovf},   {7'd0, exp_ovf1});
        check("p2_ovf",   {7'd0, p2_ovf},   {7'd0, exp_ovf2});
        if (exp_q1.size() > 0) check("p1_data", p1_data, exp_q1[0]);
        if (exp_q2.size() > 0) check("p2_data", p2_data, exp_q2[0]);
    end

    // ---------------- driver tasks ----------------
    task automatic cycle();
        @(negedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d, input logic tp);
        in_data    = d;
        two_player = tp;
        in_valid   = 1'b1;
        cycle();
        in_valid   = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    // Time limit so the run always reaches the summary.
    initial begin
        #50000;
        bad++;
        $display("FAIL timeout: simulation exceeded time limit");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // ---------------- stimulus ----------------
    initial begin
        rst        = 1'b1;
        in_data    = 8'h00;
        in_valid   = 1'b0;
        two_player = 1'b0;
        p1_ready   = 1'b0;
        p2_ready   = 1'b0;
        clr_ovf    = 1'b0;
        idle(2);
        check("rst_p1_valid", {7'd0, p1_valid}, 8'h00);
        check("rst_p2_valid", {7'd0, p2_valid}, 8'h00);
        check("rst_p1_data",  p1_data, 8'h00);
        check("rst_p2_data",  p2_data, 8'h00);
        check("rst_ovf",      {6'd0, p2_ovf, p1_ovf}, 8'h00);
        rst = 1'b0;
        cycle();

        // Two-player steering with idle consumers.
        send(8'h7F, 1'b1);
        check("steer_latency", p1_data, 8'h7F);
        send(8'h80, 1'b1);
        send(8'hFF, 1'b1);
        send(8'h00, 1'b1);
        check("steer_p1_head", p1_data, 8'h7F);
        check("steer_p2_head", p2_data, 8'h80);
        check("steer_ovf", {6'd0, p2_ovf, p1_ovf}, 8'h00);
        p1_ready = 1'b1;
        cycle();
        p1_ready = 1'b0;
        check("steer_p1_second", p1_data, 8'h00);
        p2_ready = 1'b1;
        cycle();
        p2_ready = 1'b0;
        check("steer_p2_second", p2_data, 8'hFF);
        p1_ready = 1'b1;
        p2_ready = 1'b1;
        idle(2);
        check("steer_drained", {6'd0, p2_valid, p1_valid}, 8'h00);

        // Broadcast with independent ready patterns.
        p2_ready = 1'b0;
        send(8'h05, 1'b0);
        check("bc_p1_first", p1_data, 8'h05);
        check("bc_p2_first", p2_data, 8'h05);
        send(8'h06, 1'b0);
        check("bc_p1_second", p1_data, 8'h06);
        check("bc_p2_hold",   p2_data, 8'h05);
        for (int i = 0; i < 9; i++) begin
            p2_ready = (i % 3 == 2);
            cycle();
        end
        p2_ready = 1'b0;
        check("bc_drained", {6'd0, p2_valid, p1_valid}, 8'h00);

        // Overflow in two-player mode, P1 never ready.
        p1_ready = 1'b0;
        for (int i = 1; i <= 5; i++) send(8'(i), 1'b1);
        check("ovf_p1_set",   {7'd0, p1_ovf}, 8'h01);
        check("ovf_p2_clear", {7'd0, p2_ovf}, 8'h00);
        check("ovf_p1_head",  p1_data, 8'h01);
        clr_ovf = 1'b1;
        cycle();
        clr_ovf = 1'b0;
        check("ovf_cleared", {7'd0, p1_ovf}, 8'h00);

        // Atomic broadcast drop: P1 still full, P2 empty.
        send(8'h42, 1'b0);
        check("atomic_p1_ovf", {7'd0, p1_ovf}, 8'h01);
        check("atomic_p2_ovf", {7'd0, p2_ovf}, 8'h00);
        check("atomic_p2_empty", {7'd0, p2_valid}, 8'h00);
        check("atomic_p1_head", p1_data, 8'h01);
        p1_ready = 1'b1;
        clr_ovf  = 1'b1;
        idle(4);
        p1_ready = 1'b0;
        clr_ovf  = 1'b0;
        check("atomic_p1_drained", {7'd0, p1_valid}, 8'h00);

        // Full P2 with a simultaneous pop accepts the push.
        send(8'hA1, 1'b1);
        send(8'hA2, 1'b1);
        send(8'hA3, 1'b1);
        send(8'hA4, 1'b1);
        p2_ready = 1'b1;
        send(8'hA0, 1'b1);
        p2_ready = 1'b0;
        check("fullpop_head", p2_data, 8'hA2);
        check("fullpop_ovf",  {7'd0, p2_ovf}, 8'h00);
        p2_ready = 1'b1;
        idle(3);
        p2_ready = 1'b0;
        check("fullpop_order", p2_data, 8'hA0);
        check("fullpop_valid", {7'd0, p2_valid}, 8'h01);
        p2_ready = 1'b1;
        cycle();
        p2_ready = 1'b0;
        check("fullpop_drained", {7'd0, p2_valid}, 8'h00);

        // Asynchronous reset while P1 holds 3 bytes.
        send(8'h01, 1'b1);
        send(8'h02, 1'b1);
        send(8'h03, 1'b1);
        check("prerst_p1_head", p1_data, 8'h01);
        #2;
        rst = 1'b1;
        #1;
        check("async_p1_valid", {7'd0, p1_valid}, 8'h00);
        check("async_p1_ovf",   {7'd0, p1_ovf},   8'h00);
        check("async_p1_data",  p1_data, 8'h00);
        cycle();
        rst = 1'b0;
        cycle();
        send(8'h11, 1'b1);
        check("postrst_valid", {7'd0, p1_valid}, 8'h01);
        check("postrst_data",  p1_data, 8'h11);
        idle(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_key_demux
